cpu16_mem_responder: RTL and testbench

- Bus responder for the cpu16 memory port. It is the target side of the addr/mw/dout/din interface that cpu16 drives.
- It replaces the bare RAM with three things: a synchronous RAM, a small memory-mapped I/O page, and a power-up RAM-clear sequencer.
- Sits between cpu16 and the board outputs in the kit top level, on the CPU memory clock domain.

---
 rtl/cpu16_mem_responder.sv | 142 ++++++++++++++
 tb/tb_cpu16_mem_responder.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/cpu16_mem_responder.sv
// Target side of the cpu16 memory port: synchronous RAM, a small I/O page at
// the top of the address space, and a RAM-clear sequencer that runs after reset.
module cpu16_mem_responder #(
  parameter int BW         = 16,
  parameter int AW         = 9,
  parameter int CLR_ON_RST = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] addr,
  input  logic          mw,
  input  logic [BW-1:0] dout,
  output logic [BW-1:0] din,
  output logic          ready,
  output logic [BW-1:0] port0,
  output logic [BW-1:0] port1,
  output logic          tmr_flag
);

  localparam int            RAM_WORDS = (1 << AW) - 16;
  localparam logic [AW-1:0] A_PORT0   = AW'(RAM_WORDS);
  localparam logic [AW-1:0] A_PORT1   = AW'(RAM_WORDS + 1);
  localparam logic [AW-1:0] A_CYCLE   = AW'(RAM_WORDS + 2);
  localparam logic [AW-1:0] A_TIMER   = AW'(RAM_WORDS + 3);
  localparam logic [AW-1:0] A_STATUS  = AW'(RAM_WORDS + 4);
  localparam logic [AW-1:0] PTR_LAST  = AW'(RAM_WORDS - 1);

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t        state_q;
  logic [AW-1:0] ptr_q;
  logic          ready_q;
  logic [BW-1:0] din_q, port0_q, port1_q, cycle_q, timer_q;
  logic          flag_q;

  logic [BW-1:0] timer_d, rd_d, status_w;
  logic          flag_d, expire, run, is_ram;
  logic          wr_port0, wr_port1, wr_timer, wr_status;

  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [BW-1:0] ram_wdata;
  logic [BW-1:0] ram [RAM_WORDS];

  assign run       = (state_q == ST_RUN);
  assign is_ram    = (addr < A_PORT0);
  assign wr_port0  = run && mw && (addr == A_PORT0);
  assign wr_port1  = run && mw && (addr == A_PORT1);
  assign wr_timer  = run && mw && (addr == A_TIMER);
  assign wr_status = run && mw && (addr == A_STATUS);
  assign status_w  = {{(BW-2){1'b0}}, ready_q, flag_q};
  assign expire    = run && (timer_q == BW'(1));

  // The clear sequencer owns the RAM write port until the state reaches RUN.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = addr;
    ram_wdata = dout;
    if (!run) begin
      ram_we    = 1'b1;
      ram_waddr = ptr_q;
      ram_wdata = '0;
    end else if (mw && is_ram) begin
      ram_we = 1'b1;
    end
  end

  // NOTE: the RAM array has no reset; clearing it is the sequencer's job, and
  // a reset term here would stop it mapping onto a block RAM.
  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_waddr] <= ram_wdata;
  end

  // Read mux: write-first for storage locations, pre-update value for CYCLE/STATUS.
  always_comb begin
    rd_d = '0;
    if (is_ram) begin
      rd_d = mw ? dout : ram[addr];
    end else begin
      unique case (addr)
        A_PORT0:  rd_d = mw ? dout : port0_q;
        A_PORT1:  rd_d = mw ? dout : port1_q;
        A_CYCLE:  rd_d = cycle_q;
        A_TIMER:  rd_d = mw ? dout : timer_q;
        A_STATUS: rd_d = status_w;
        default:  rd_d = '0;
      endcase
    end
  end

  always_comb begin
    timer_d = timer_q;
    if (run) begin
      if (wr_timer)              timer_d = dout;
      else if (timer_q != '0)    timer_d = timer_q - BW'(1);
    end
    flag_d = expire | (flag_q & ~(wr_status & dout[0]));
  end

  // NOTE: every register here uses non-blocking assignment so all state
  // updates see the same pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= (CLR_ON_RST != 0) ? ST_CLEAR : ST_RUN;
      ready_q <= (CLR_ON_RST == 0);
      ptr_q   <= '0;
      din_q   <= '0;
      port0_q <= '0;
      port1_q <= '0;
      cycle_q <= '0;
      timer_q <= '0;
      flag_q  <= 1'b0;
    end else begin
      timer_q <= timer_d;
      flag_q  <= flag_d;
      unique case (state_q)
        ST_CLEAR: begin
          din_q <= '0;
          ptr_q <= ptr_q + AW'(1);
          if (ptr_q == PTR_LAST) begin
            state_q <= ST_RUN;
            ready_q <= 1'b1;
          end
        end
        ST_RUN: begin
          din_q   <= rd_d;
          cycle_q <= cycle_q + BW'(1);
          if (wr_port0) port0_q <= dout;
          if (wr_port1) port1_q <= dout;
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  assign din      = din_q;
  assign ready    = ready_q;
  assign port0    = port0_q;
  assign port1    = port1_q;
  assign tmr_flag = flag_q;

endmodule

// File: tb/tb_cpu16_mem_responder.sv
// Randomized self-checking bench for cpu16_mem_responder against a
// transaction-level model of the memory map, clear sequence and timer.
module tb_cpu16_mem_responder;

  localparam int RAM_WORDS = 496;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [8:0]  addr = '0;
  logic        mw = 1'b0;
  logic [15:0] dout = '0;
  logic [15:0] din, port0, port1;
  logic        ready, tmr_flag;

  logic [8:0]  addr4 = 9'h1F2;
  logic        mw4 = 1'b0;
  logic [3:0]  dout4 = '0;
  logic [3:0]  din4, port0_4, port1_4;
  logic        ready4, tmr_flag4;

  int total = 0;
  int bad = 0;

  // Reference model state
  logic [15:0] m_mem [RAM_WORDS];
  logic [15:0] m_p0, m_p1, m_cyc, m_tmr, m_din;
  logic        m_flag, m_run;
  int          m_clr_cnt;
  int          m4_cyc;

  cpu16_mem_responder dut (
    .clk(clk), .rst(rst), .addr(addr), .mw(mw), .dout(dout),
    .din(din), .ready(ready), .port0(port0), .port1(port1), .tmr_flag(tmr_flag)
  );

  cpu16_mem_responder #(.BW(4), .AW(9), .CLR_ON_RST(0)) dut4 (
    .clk(clk), .rst(rst), .addr(addr4), .mw(mw4), .dout(dout4),
    .din(din4), .ready(ready4), .port0(port0_4), .port1(port1_4), .tmr_flag(tmr_flag4)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_p0 = '0; m_p1 = '0; m_cyc = '0; m_tmr = '0; m_din = '0;
    m_flag = 1'b0; m_run = 1'b0; m_clr_cnt = 0; m4_cyc = 0;
  endtask

  // Apply one bus cycle: update the model for the edge, then compare outputs.
  task automatic step(input logic [8:0] a, input logic w, input logic [15:0] d);
    int ai;
    logic expire;
    addr = a; mw = w; dout = d;
    @(posedge clk);
    ai = int'(a);
    if (!m_run) begin
      m_din = '0;
      m_clr_cnt++;
      if (m_clr_cnt == RAM_WORDS) begin
        m_run = 1'b1;
        for (int i = 0; i < RAM_WORDS; i++) m_mem[i] = '0;
      end
    end else begin
      if (ai < RAM_WORDS)      m_din = w ? d : m_mem[ai];
      else if (ai == 'h1F0)    m_din = w ? d : m_p0;
      else if (ai == 'h1F1)    m_din = w ? d : m_p1;
      else if (ai == 'h1F2)    m_din = m_cyc;
      else if (ai == 'h1F3)    m_din = w ? d : m_tmr;
      else if (ai == 'h1F4)    m_din = {14'd0, 1'b1, m_flag};
      else                     m_din = '0;
      expire = (m_tmr == 16'd1);
      if (w && ai < RAM_WORDS) m_mem[ai] = d;
      if (w && ai == 'h1F0)    m_p0 = d;
      if (w && ai == 'h1F1)    m_p1 = d;
      if (w && ai == 'h1F3)    m_tmr = d;
      else if (m_tmr != 0)     m_tmr = m_tmr - 16'd1;
      if (expire)                          m_flag = 1'b1;
      else if (w && ai == 'h1F4 && d[0])   m_flag = 1'b0;
      m_cyc = m_cyc + 16'd1;
    end
    #1;
    check("din", din, m_din);
    check("ready", ready, m_run);
    check("port0", port0, m_p0);
    check("port1", port1, m_p1);
    check("tmr_flag", tmr_flag, m_flag);
    check("cycle4", din4, m4_cyc % 16);
    m4_cyc++;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #2;
    check("rst_din", din, 0);
    check("rst_ready", ready, 0);
    check("rst_port0", port0, 0);
    check("rst_port1", port1, 0);
    check("rst_flag", tmr_flag, 0);
    check("rst_ready4", ready4, 1);
    check("rst_din4", din4, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic random_cycle();
    logic [8:0]  a;
    logic        w;
    logic [15:0] d;
    case ($urandom_range(0, 3))
      0: a = 9'($urandom_range(0, 15));
      1: a = 9'($urandom_range('h1F0, 'h1FF));
      2: a = 9'($urandom);
      default: a = ($urandom_range(0, 1) == 0) ? 9'h1F3 : 9'h1F4;
    endcase
    w = ($urandom_range(0, 2) == 0);
    d = 16'($urandom);
    if (a == 9'h1F3) d = 16'($urandom_range(0, 12));
    step(a, w, d);
  endtask

  initial begin
    logic [15:0] c1;
    model_reset();
    #23;
    apply_reset();

    // CLEAR phase with bus writes that must be ignored
    for (int e = 1; e <= RAM_WORDS; e++) begin
      if (e % 7 == 0) step(9'(e % 16), 1'b1, 16'hDEAD);
      else if (e % 11 == 0) step(9'h1F3, 1'b1, 16'd3);
      else step(9'h1F0, 1'b1, 16'($urandom));
      if (e == RAM_WORDS - 1) check("ready_low_495", ready, 0);
      if (e == RAM_WORDS)     check("ready_high_496", ready, 1);
    end

    step(9'h000, 1'b0, '0); check("ram0_cleared", din, 16'h0000);
    step(9'h1EF, 1'b0, '0); check("ram1ef_cleared", din, 16'h0000);
    step(9'h007, 1'b0, '0); check("clear_write_ignored", din, 16'h0000);
    check("timer_frozen_flag", tmr_flag, 0);

    step(9'h005, 1'b1, 16'h1234);
    step(9'h005, 1'b0, '0);       check("ram_rd", din, 16'h1234);
    step(9'h007, 1'b1, 16'hBEEF); check("rdw_first", din, 16'hBEEF);
    step(9'h1F0, 1'b1, 16'h00FF);
    step(9'h1F1, 1'b1, 16'hA5A5); check("port0_wr", port0, 16'h00FF);
    step(9'h1F8, 1'b0, '0);       check("port1_wr", port1, 16'hA5A5);
    check("reserved_rd", din, 16'h0000);
    step(9'h1F2, 1'b1, 16'h7777); // CYCLE write ignored

    step(9'h1F3, 1'b1, 16'd5);
    for (int i = 1; i <= 4; i++) begin
      step(9'h1F3, 1'b0, '0);
      check("tmr_not_yet", tmr_flag, 0);
    end
    step(9'h1F3, 1'b0, '0); check("tmr_expired", tmr_flag, 1);
    step(9'h1F3, 1'b0, '0); check("tmr_zero", din, 16'd0);
    step(9'h1F4, 1'b0, '0); check("status_rd", din, 16'h0003);
    step(9'h1F4, 1'b1, 16'h0001); check("flag_cleared", tmr_flag, 0);
    step(9'h1F3, 1'b1, 16'd0);
    step(9'h1F3, 1'b0, '0); check("tmr_load0_noflag", tmr_flag, 0);
    step(9'h1F3, 1'b1, 16'd3);
    step(9'h1F3, 1'b0, '0);
    step(9'h1F3, 1'b0, '0);
    step(9'h1F4, 1'b1, 16'h0001); check("set_wins", tmr_flag, 1);
    step(9'h1F4, 1'b1, 16'h0001); check("flag_clr2", tmr_flag, 0);

    step(9'h1F2, 1'b0, '0); c1 = din;
    for (int i = 0; i < 9; i++) step(9'h000, 1'b0, '0);
    step(9'h1F2, 1'b0, '0); check("cycle_delta", din - c1, 16'd10);

    for (int i = 0; i < 2000; i++) random_cycle();

    // Reset in the middle of CLEAR restarts the sequence from pointer 0
    apply_reset();
    for (int e = 1; e <= 200; e++) step(9'h010, 1'b1, 16'h5555);
    apply_reset();
    for (int e = 1; e <= RAM_WORDS; e++) begin
      step(9'h010, 1'b1, 16'h5555);
      if (e == RAM_WORDS - 1) check("rst2_ready_low", ready, 0);
      if (e == RAM_WORDS)     check("rst2_ready_high", ready, 1);
    end
    step(9'h010, 1'b0, '0); check("rst2_ram_cleared", din, 16'h0000);
    for (int i = 0; i < 300; i++) random_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
